// File: rtl/ddr3_memtest.sv
// ddr3_memtest: AXI4 write/read-back pattern tester for the DDR3 controller.
// Writes an LFSR pattern over NUM_BURSTS INCR bursts, reads it back, and
// counts response, framing and data errors. One transaction is outstanding
// at a time, and every handshake/status output comes straight from a flop.
module ddr3_memtest #(
  parameter int               DATA_WIDTH = 32,
  parameter int               ADDRS      = 27,
  parameter int               REQID      = 4,
  parameter int               BURST_LEN  = 8,
  parameter int               NUM_BURSTS = 64,
  parameter logic [ADDRS-1:0] BASE_ADDR  = {ADDRS{1'b0}},
  parameter logic [31:0]      SEED       = 32'h0000_0001
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    configured_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [15:0]             err_count_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [ADDRS-1:0]        awaddr_o,
  output logic [REQID-1:0]        awid_o,
  output logic [7:0]              awlen_o,
  output logic [1:0]              awburst_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic                    wlast_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  input  logic [1:0]              bresp_i,
  input  logic [REQID-1:0]        bid_i,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  output logic [ADDRS-1:0]        araddr_o,
  output logic [REQID-1:0]        arid_o,
  output logic [7:0]              arlen_o,
  output logic [1:0]              arburst_o,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  input  logic                    rlast_i,
  input  logic [1:0]              rresp_i,
  input  logic [REQID-1:0]        rid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_WR_RESP = 3'd3;
  localparam logic [2:0] ST_RD_ADDR = 3'd4;
  localparam logic [2:0] ST_RD_DATA = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam int               BCW         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [BCW-1:0]   LAST_BURST  = BCW'(NUM_BURSTS - 1);
  localparam logic [BCW-1:0]   BURST_ONE   = BCW'(1);
  localparam logic [7:0]       LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [ADDRS-1:0] BURST_BYTES = ADDRS'(BURST_LEN * 4);
  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [31:0]      SEED_EFF    = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

  // Galois LFSR step shared by the write generator and the read checker.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  logic [2:0]       state_r;
  logic [31:0]      lfsr_r;
  logic [ADDRS-1:0] addr_r;
  logic [BCW-1:0]   burst_r;
  logic [7:0]       beat_r;
  logic [15:0]      err_cnt_r;
  logic             awvalid_r, wvalid_r, wlast_r, bready_r, arvalid_r, rready_r;
  logic             busy_r, done_r, pass_r;
  logic             err_hit_s;
  logic [15:0]      err_next_s;
  logic             unused_s;

  assign awaddr_o    = addr_r;
  assign araddr_o    = addr_r;
  assign awid_o      = {REQID{1'b0}};
  assign arid_o      = {REQID{1'b0}};
  assign awlen_o     = LAST_BEAT;
  assign arlen_o     = LAST_BEAT;
  assign awburst_o   = 2'b01;
  assign arburst_o   = 2'b01;
  assign wstrb_o     = {(DATA_WIDTH/8){1'b1}};
  assign wdata_o     = lfsr_r;
  assign awvalid_o   = awvalid_r;
  assign wvalid_o    = wvalid_r;
  assign wlast_o     = wlast_r;
  assign bready_o    = bready_r;
  assign arvalid_o   = arvalid_r;
  assign rready_o    = rready_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign pass_o      = pass_r;
  assign err_count_o = err_cnt_r;
  // Response IDs are always 0 with a single outstanding transaction.
  assign unused_s    = ^{bid_i, rid_i};

  // Error detection for the current cycle's handshake and saturating increment.
  always_comb begin
    err_hit_s  = 1'b0;
    err_next_s = err_cnt_r;
    case (state_r)
      ST_WR_RESP: begin
        if (bvalid_i && bready_r) begin
          err_hit_s = (bresp_i != 2'b00);
        end else begin
          err_hit_s = 1'b0;
        end
      end
      ST_RD_DATA: begin
        if (rvalid_i && rready_r) begin
          err_hit_s = (rdata_i != lfsr_r) || (rresp_i != 2'b00) ||
                      (rlast_i != (beat_r == LAST_BEAT));
        end else begin
          err_hit_s = 1'b0;
        end
      end
      default: err_hit_s = 1'b0;
    endcase
    if (err_hit_s && (err_cnt_r != 16'hFFFF)) begin
      err_next_s = err_cnt_r + 16'd1;
    end else begin
      err_next_s = err_cnt_r;
    end
  end

  // Test sequencer: FSM, pattern/address generators and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      lfsr_r    <= SEED_EFF;
      addr_r    <= BASE_ADDR;
      burst_r   <= {BCW{1'b0}};
      beat_r    <= 8'd0;
      err_cnt_r <= 16'd0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      wlast_r   <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      err_cnt_r <= err_next_s;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_i && configured_i) begin
            state_r   <= ST_WR_ADDR;
            lfsr_r    <= SEED_EFF;
            addr_r    <= BASE_ADDR;
            burst_r   <= {BCW{1'b0}};
            beat_r    <= 8'd0;
            err_cnt_r <= 16'd0;
            awvalid_r <= 1'b1;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
          end
        end
        ST_WR_ADDR: begin
          if (awready_i) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            wlast_r   <= (LAST_BEAT == 8'd0);
            beat_r    <= 8'd0;
            state_r   <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (wready_i) begin
            lfsr_r <= lfsr_next(lfsr_r);
            if (beat_r == LAST_BEAT) begin
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state_r  <= ST_WR_RESP;
            end else begin
              beat_r  <= beat_r + 8'd1;
              wlast_r <= ((beat_r + 8'd1) == LAST_BEAT);
            end
          end
        end
        ST_WR_RESP: begin
          if (bvalid_i) begin
            bready_r <= 1'b0;
            if (burst_r == LAST_BURST) begin
              lfsr_r    <= SEED_EFF;
              addr_r    <= BASE_ADDR;
              burst_r   <= {BCW{1'b0}};
              arvalid_r <= 1'b1;
              state_r   <= ST_RD_ADDR;
            end else begin
              addr_r    <= addr_r + BURST_BYTES;
              burst_r   <= burst_r + BURST_ONE;
              awvalid_r <= 1'b1;
              state_r   <= ST_WR_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (arready_i) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            beat_r    <= 8'd0;
            state_r   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (rvalid_i) begin
            lfsr_r <= lfsr_next(lfsr_r);
            if (beat_r == LAST_BEAT) begin
              rready_r <= 1'b0;
              addr_r   <= addr_r + BURST_BYTES;
              if (burst_r == LAST_BURST) begin
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                pass_r  <= (err_next_s == 16'd0);
                state_r <= ST_DONE;
              end else begin
                burst_r   <= burst_r + BURST_ONE;
                arvalid_r <= 1'b1;
                state_r   <= ST_RD_ADDR;
              end
            end else begin
              beat_r <= beat_r + 8'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
